fft_bfly_sched: RTL and testbench
=================================

// Module: fft_bfly_sched
// PURPOSE
//  Butterfly scheduler for the in-place radix-2 DIT FFT datapath (data RAM + twiddle ROM + mul/add-sub pipe).
//  Issues one butterfly descriptor per handshake: u/v RAM addresses, twiddle address, stage index.
//  Enforces a stage barrier: no butterfly of stage s+1 issues until every stage-s writeback is acknowledged.
//  Sits between the top-level control (start/abort) and the butterfly datapath.
// PARAMETERS
//  FFT_SIZE  16  transform length; power of two, >= 4
//  MAX_OUT   4   max butterflies issued but not yet written back (1..15)
//  ADDR_W    $clog2(FFT_SIZE)  address width (derived, not overridden)
// PORTS
//  clk_i        in   1                      clock
//  rst_ni       in   1                      reset, asynchronous, active-low
//  start_i      in   1                      start a full transform (sampled in IDLE only)
//  abort_i      in   1                      synchronous abort, returns to IDLE
//  bfly_valid_o out  1                      descriptor valid
//  bfly_ready_i in   1                      datapath accepts descriptor
//  u_addr_o     out  ADDR_W                 upper-leg RAM address
//  v_addr_o     out  ADDR_W                 lower-leg RAM address
//  tw_addr_o    out  ADDR_W                 twiddle ROM address
//  stage_o      out  $clog2(ADDR_W+1)       current stage 0..ADDR_W-1
//  wb_done_i    in   1                      one butterfly written back to RAM
//  busy_o       out  1                      high in any state except IDLE
//  done_o       out  1                      1-cycle pulse, transform complete
//  err_o        out  1                      sticky: wb_done_i seen with zero outstanding
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters s,g,k and outstanding cleared; err_o cleared.
//  Indexing: L = ADDR_W, half = 1<<s.
//   u = g*2*half + k, v = u + half, tw = k << (L-1-s).
//   Ordering: k (0..half-1) innermost, then g (0..FFT_SIZE/(2*half)-1), then s (0..L-1).
//   FFT_SIZE/2 butterflies per stage. All arithmetic is unsigned ADDR_W; no wrap can occur for legal indices.
//  FSM:
//   IDLE -> ISSUE on start_i; err_o cleared, s=g=k=0.
//   ISSUE: bfly_valid_o = (outstanding < MAX_OUT). Accept = valid & ready.
//    On accept, advance k/g. On the last butterfly of the stage -> DRAIN.
//   DRAIN: bfly_valid_o = 0; wait outstanding == 0.
//    Then, if s < L-1: s++, g=k=0 -> ISSUE. Else -> DONE.
//   DONE: done_o = 1 for exactly one cycle -> IDLE.
//  Handshake: once valid is asserted, payload and valid are held stable until accepted; no combinational path ready->valid.
//  Latency:
//   - first bfly_valid_o is asserted the cycle after start_i is sampled.
//   - from DRAIN, the next stage's first valid is asserted the cycle after outstanding reaches 0.
//   - done_o is asserted the cycle after the final outstanding decrement.
//  Outstanding counter:
//   - +1 on accept, -1 on wb_done_i; both in the same cycle -> unchanged.
//   - wb_done_i at 0 outstanding (and no same-cycle accept): ignored, sets err_o.
//  start_i while busy_o: ignored.
//  abort_i (any state): next cycle IDLE, valid low, counters and outstanding cleared, no done_o; abort has priority over start_i.
//  Async reset mid-transform: immediate IDLE per reset values; datapath is expected to be reset alongside.
// TESTING (FFT_SIZE=16, MAX_OUT=4 unless noted)
//  T1 ready=1, wb_done_i 2 cycles after each accept ->
//     32 accepts, 8 per stage; one done_o pulse; busy_o falls with done_o.
//  T2 index check ->
//     stage0 #0: u=0,v=1,tw=0; stage1 g=0,k=1: u=1,v=3,tw=4;
//     stage2 g=1,k=3: u=11,v=15,tw=6; stage3 k=5: u=5,v=13,tw=5.
//  T3 ready=1, wb_done_i never -> exactly 4 accepts, then valid stays low;
//     one wb_done_i -> exactly one more accept.
//  T4 stage barrier: delay the 8th stage-0 wb_done_i by 20 cycles ->
//     no stage-1 valid until the cycle after it.
//  T5 ready toggled randomly -> payload stable while valid & !ready; sequence identical to T2 order.
//  T6 abort_i mid stage 2, then start_i -> restart at s=0,u=0; no done_o for the aborted run.
//     Also: wb_done_i in IDLE -> err_o=1, cleared by the next start_i.

Source files
------------

// File: rtl/fft_bfly_sched.sv
// Butterfly scheduler for an in-place radix-2 DIT FFT.
// Walks stages s, groups g and in-group offsets k, and issues one
// {u, v, twiddle, stage} descriptor per handshake to the butterfly pipe.
// A stage barrier holds back stage s+1 until every stage-s writeback is in.
//
// Handshake (descriptor port): bfly_valid_o is a function of registered
// state only, so there is no combinational path from bfly_ready_i to
// bfly_valid_o. A transfer happens on a rising edge where bfly_valid_o and
// bfly_ready_i are both high. Once valid is raised, it and the payload hold
// until that transfer: the payload comes from counters that move only on a
// transfer, and valid can only fall when the outstanding count rises, which
// also happens only on a transfer. Abort and reset are the only exceptions.
module fft_bfly_sched #(
   parameter int unsigned FFT_SIZE = 16,
   parameter int unsigned MAX_OUT  = 4,
   localparam int unsigned ADDR_W  = $clog2(FFT_SIZE),
   localparam int unsigned STG_W   = $clog2(ADDR_W + 1),
   localparam int unsigned OUT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   output logic              bfly_valid_o,
   input  logic              bfly_ready_i,
   output logic [ADDR_W-1:0] u_addr_o,
   output logic [ADDR_W-1:0] v_addr_o,
   output logic [ADDR_W-1:0] tw_addr_o,
   output logic [STG_W-1:0]  stage_o,
   input  logic              wb_done_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [STG_W-1:0]  LAST_S    = STG_W'(ADDR_W - 1);
   localparam logic [OUT_W-1:0]  MAX_OUT_W = OUT_W'(MAX_OUT);
   localparam logic [ADDR_W:0]   N_W       = (ADDR_W + 1)'(FFT_SIZE);
   localparam logic [ADDR_W:0]   ONE_W     = (ADDR_W + 1)'(1);

   logic [1:0]        state_q, state_d;
   logic [STG_W-1:0]  s_q, s_d;
   logic [ADDR_W-1:0] g_q, g_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              err_q;

   logic              accept;
   logic              stray_wb;
   logic              last_k;
   logic              last_g;
   logic [ADDR_W:0]   half_w;
   logic [ADDR_W:0]   grp_w;
   logic [STG_W-1:0]  tw_sh;
   logic [ADDR_W-1:0] u_w;
   logic              in_issue;

   // Stage geometry: butterfly span and number of groups in the current stage.
   always_comb begin
      half_w = ONE_W << s_q;
      grp_w  = (N_W >> s_q) >> 1;
      last_k = (({1'b0, k_q} + ONE_W) == half_w);
      last_g = (({1'b0, g_q} + ONE_W) == grp_w);
      tw_sh  = LAST_S - s_q;
      u_w    = ((g_q << s_q) << 1) + k_q;
   end

   // Descriptor outputs and status; payload reads zero outside ISSUE.
   always_comb begin
      in_issue     = (state_q == ST_ISSUE);
      bfly_valid_o = in_issue && (out_q < MAX_OUT_W);
      u_addr_o     = in_issue ? u_w : '0;
      v_addr_o     = in_issue ? (u_w + half_w[ADDR_W-1:0]) : '0;
      tw_addr_o    = in_issue ? (k_q << tw_sh) : '0;
      stage_o      = s_q;
      busy_o       = (state_q != ST_IDLE);
      done_o       = (state_q == ST_DONE);
      err_o        = err_q;
   end

   assign accept   = bfly_valid_o && bfly_ready_i;
   assign stray_wb = wb_done_i && (out_q == '0) && !accept;

   // Next-state logic: outstanding tracking, index walk and stage barrier.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      g_d     = g_q;
      k_d     = k_q;
      out_d   = out_q;

      if (accept && !wb_done_i) begin
         out_d = out_q + OUT_W'(1);
      end else if (!accept && wb_done_i && (out_q != '0)) begin
         out_d = out_q - OUT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_ISSUE;
               s_d     = '0;
               g_d     = '0;
               k_d     = '0;
            end
         end
         ST_ISSUE: begin
            if (accept) begin
               if (last_k) begin
                  k_d = '0;
                  if (last_g) begin
                     g_d     = '0;
                     state_d = ST_DRAIN;
                  end else begin
                     g_d = g_q + ADDR_W'(1);
                  end
               end else begin
                  k_d = k_q + ADDR_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            // Looking at the next count lets the following stage start the
            // cycle right after the last writeback lands.
            if (out_d == '0) begin
               if (s_q == LAST_S) begin
                  state_d = ST_DONE;
               end else begin
                  s_d     = s_q + STG_W'(1);
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            s_d     = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort_i) begin
         state_d = ST_IDLE;
         s_d     = '0;
         g_d     = '0;
         k_d     = '0;
         out_d   = '0;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         g_q     <= '0;
         k_q     <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         g_q     <= g_d;
         k_q     <= k_d;
         out_q   <= out_d;
      end
   end

   // Sticky writeback-without-issue error, cleared when a new run starts.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (stray_wb) begin
         err_q <= 1'b1;
      end else if ((state_q == ST_IDLE) && start_i && !abort_i) begin
         err_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed bench for fft_bfly_sched (FFT_SIZE=16, MAX_OUT=4).
// A cycle driver models the datapath (ready, delayed writebacks), logs
// every accepted descriptor and checks it against an expected queue.
module tb_fft_bfly_sched;

   localparam int FFT_SIZE = 16;
   localparam int MAX_OUT  = 4;
   localparam int AW       = 4;
   localparam int SW       = 3;
   localparam int W        = SW + 3 * AW;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic          bfly_ready_i = 1'b0;
   logic          wb_done_i = 1'b0;
   logic          bfly_valid_o;
   logic [AW-1:0] u_addr_o;
   logic [AW-1:0] v_addr_o;
   logic [AW-1:0] tw_addr_o;
   logic [SW-1:0] stage_o;
   logic          busy_o;
   logic          done_o;
   logic          err_o;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] acc_log[$];
   int           wb_due[$];
   int           cyc = 0;
   int           wb_delay = 2;
   int           hold_idx = -1;
   int           hold_extra = 0;
   int           n_acc = 0;
   int           done_cnt = 0;
   int           stage_acc[AW];

   logic         obs_valid = 1'b0;
   logic         obs_busy = 1'b0;
   logic         obs_done = 1'b0;
   logic         obs_err = 1'b0;
   logic [W-1:0] obs_pl = '0;
   logic         hold_pend = 1'b0;
   logic [W-1:0] hold_pl = '0;

   fft_bfly_sched #(
      .FFT_SIZE (FFT_SIZE),
      .MAX_OUT  (MAX_OUT)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .bfly_valid_o (bfly_valid_o),
      .bfly_ready_i (bfly_ready_i),
      .u_addr_o     (u_addr_o),
      .v_addr_o     (v_addr_o),
      .tw_addr_o    (tw_addr_o),
      .stage_o      (stage_o),
      .wb_done_i    (wb_done_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   // Clock.
   always #5 clk_i = ~clk_i;

   // Expected descriptor order: k innermost, then g, then s.
   task automatic build_exp();
      int half;
      int uu;
      exp_q.delete();
      for (int s = 0; s < AW; s++) begin
         half = 1 << s;
         for (int g = 0; g < FFT_SIZE / (2 * half); g++) begin
            for (int k = 0; k < half; k++) begin
               uu = g * 2 * half + k;
               exp_q.push_back({SW'(s), AW'(uu), AW'(uu + half), AW'(k << (AW - 1 - s))});
            end
         end
      end
   endtask

   // One clock of the datapath model: sample at negedge, then drive inputs.
   task automatic run_cycle(input logic rdy, input logic st, input logic ab);
      logic [W-1:0] e;
      int           sidx;
      @(negedge clk_i);
      cyc++;
      obs_valid = bfly_valid_o;
      obs_pl    = {stage_o, u_addr_o, v_addr_o, tw_addr_o};
      obs_busy  = busy_o;
      obs_done  = done_o;
      obs_err   = err_o;
      if (obs_done) done_cnt++;
      if (hold_pend) begin
         checks++;
         if (obs_valid !== 1'b1 || obs_pl !== hold_pl) begin
            errors++;
            $display("FAIL hold_stable: valid=%b payload=%h, required valid=1 payload=%h",
                     obs_valid, obs_pl, hold_pl);
         end
      end
      start_i      = st;
      abort_i      = ab;
      bfly_ready_i = rdy;
      hold_pend    = obs_valid && !rdy && !ab;
      hold_pl      = obs_pl;
      if (obs_valid && rdy) begin
         n_acc++;
         acc_log.push_back(obs_pl);
         sidx = int'(obs_pl[W-1 -: SW]);
         if (sidx < AW) stage_acc[sidx]++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got payload %h, required no further accept", obs_pl);
         end else begin
            e = exp_q.pop_front();
            if (obs_pl !== e) begin
               errors++;
               $display("FAIL sb_payload #%0d: got %h, required %h", n_acc - 1, obs_pl, e);
            end
         end
         if (wb_delay >= 0)
            wb_due.push_back(cyc + wb_delay + ((n_acc - 1 == hold_idx) ? hold_extra : 0));
      end
      wb_done_i = 1'b0;
      if (wb_due.size() > 0 && wb_due[0] <= cyc) begin
         wb_done_i = 1'b1;
         void'(wb_due.pop_front());
      end
   endtask

   // Fresh scoreboard and a one-cycle start pulse.
   task automatic start_run();
      build_exp();
      acc_log.delete();
      wb_due.delete();
      n_acc     = 0;
      done_cnt  = 0;
      hold_pend = 1'b0;
      for (int i = 0; i < AW; i++) stage_acc[i] = 0;
      run_cycle(1'b1, 1'b1, 1'b0);
   endtask

   task automatic run_to_done(input int budget, input bit rand_rdy, input string tag);
      int n;
      n = 0;
      while (!obs_done && n < budget) begin
         run_cycle(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
         n++;
      end
      checks++;
      if (!obs_done) begin
         errors++;
         $display("FAIL %s_timeout: done_o not seen in %0d cycles", tag, budget);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({bfly_valid_o, busy_o, done_o, err_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: valid,busy,done,err=%b required 0000",
                  {bfly_valid_o, busy_o, done_o, err_o});
      end
      checks++;
      if ({stage_o, u_addr_o, v_addr_o, tw_addr_o} !== '0) begin
         errors++;
         $display("FAIL reset_payload: got %h required 0", {stage_o, u_addr_o, v_addr_o, tw_addr_o});
      end
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      run_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", obs_busy, obs_valid);
      end
   endtask

   task automatic test_full_run();
      logic [W-1:0] pts[4];
      int           idx[4];
      pts[0] = {3'd0, 4'd0,  4'd1,  4'd0}; idx[0] = 0;
      pts[1] = {3'd1, 4'd1,  4'd3,  4'd4}; idx[1] = 9;
      pts[2] = {3'd2, 4'd11, 4'd15, 4'd6}; idx[2] = 23;
      pts[3] = {3'd3, 4'd5,  4'd13, 4'd5}; idx[3] = 29;
      wb_delay = 2;
      hold_idx = -1;
      start_run();
      run_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_valid: valid=%b one cycle after start, required 1", obs_valid);
      end
      run_to_done(500, 1'b0, "full");
      checks++;
      if (n_acc != 32 || done_cnt != 1) begin
         errors++;
         $display("FAIL full_counts: accepts=%0d done=%0d, required 32 1", n_acc, done_cnt);
      end
      for (int s = 0; s < AW; s++) begin
         checks++;
         if (stage_acc[s] != 8) begin
            errors++;
            $display("FAIL stage%0d_accepts: got %0d required 8", s, stage_acc[s]);
         end
      end
      checks++;
      if (obs_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_at_done: busy=%b required 1", obs_busy);
      end
      run_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_err !== 1'b0) begin
         errors++;
         $display("FAIL after_done: busy=%b done=%b err=%b required 0 0 0", obs_busy, obs_done, obs_err);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (acc_log.size() <= idx[i] || acc_log[idx[i]] !== pts[i]) begin
            errors++;
            $display("FAIL index_pt%0d: accept #%0d payload %h, required %h", i, idx[i],
                     (acc_log.size() > idx[i]) ? acc_log[idx[i]] : '0, pts[i]);
         end
      end
   endtask

   task automatic test_max_outstanding();
      wb_delay = -1;
      start_run();
      repeat (20) run_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (n_acc != 4 || obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL max_out: accepts=%0d valid=%b, required 4 0", n_acc, obs_valid);
      end
      wb_due.push_back(cyc + 1);
      repeat (10) run_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (n_acc != 5 || obs_valid !== 1'b0 || obs_err !== 1'b0) begin
         errors++;
         $display("FAIL one_more: accepts=%0d valid=%b err=%b, required 5 0 0", n_acc, obs_valid, obs_err);
      end
      run_cycle(1'b0, 1'b0, 1'b1);
      run_cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b valid=%b required 0 0", obs_busy, obs_valid);
      end
      wb_delay = 2;
   endtask

   task automatic test_stage_barrier();
      int acc8;
      int s1;
      int n;
      acc8 = -1;
      s1   = -1;
      n    = 0;
      wb_delay   = 2;
      hold_idx   = 7;
      hold_extra = 20;
      start_run();
      while (!obs_done && n < 500) begin
         run_cycle(1'b1, 1'b0, 1'b0);
         if (n_acc == 8 && acc8 < 0) acc8 = cyc;
         if (obs_valid && obs_pl[W-1 -: SW] == 3'd1 && s1 < 0) s1 = cyc;
         n++;
      end
      hold_idx = -1;
      checks++;
      if (acc8 < 0 || s1 != acc8 + 23) begin
         errors++;
         $display("FAIL barrier: first stage-1 valid %0d cycles after 8th accept, required 23", s1 - acc8);
      end
      checks++;
      if (n_acc != 32 || done_cnt != 1) begin
         errors++;
         $display("FAIL barrier_counts: accepts=%0d done=%0d, required 32 1", n_acc, done_cnt);
      end
   endtask

   task automatic test_random_ready();
      wb_delay = 3;
      start_run();
      run_to_done(1500, 1'b1, "rand");
      checks++;
      if (n_acc != 32 || done_cnt != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_counts: accepts=%0d done=%0d left=%0d, required 32 1 0",
                  n_acc, done_cnt, exp_q.size());
      end
      wb_delay = 2;
      run_cycle(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_abort_restart();
      int n;
      n = 0;
      wb_delay = 2;
      start_run();
      while (!(obs_valid && obs_pl[W-1 -: SW] == 3'd2 && n_acc >= 18) && n < 300) begin
         run_cycle(1'b1, 1'b0, 1'b0);
         n++;
      end
      run_cycle(1'b0, 1'b0, 1'b1);
      wb_due.delete();
      run_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_pl[W-1 -: SW] !== 3'd0) begin
         errors++;
         $display("FAIL abort: busy=%b valid=%b stage=%0d, required 0 0 0",
                  obs_busy, obs_valid, obs_pl[W-1 -: SW]);
      end
      repeat (5) run_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (done_cnt != 0 || obs_err !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: done=%0d err=%b, required 0 0", done_cnt, obs_err);
      end
      wb_due.push_back(cyc + 1);
      repeat (3) run_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_err !== 1'b1) begin
         errors++;
         $display("FAIL err_set: err=%b required 1", obs_err);
      end
      start_run();
      run_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_err !== 1'b0 || obs_valid !== 1'b1 || obs_pl !== {3'd0, 4'd0, 4'd1, 4'd0}) begin
         errors++;
         $display("FAIL restart: err=%b valid=%b payload=%h, required 0 1 0010", obs_err, obs_valid, obs_pl);
      end
      run_to_done(500, 1'b0, "restart");
      checks++;
      if (n_acc != 32 || done_cnt != 1) begin
         errors++;
         $display("FAIL restart_counts: accepts=%0d done=%0d, required 32 1", n_acc, done_cnt);
      end
      run_cycle(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      wb_delay = 2;
      start_run();
      repeat (10) run_cycle(1'b1, 1'b0, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({bfly_valid_o, busy_o, done_o, err_o, stage_o} !== '0) begin
         errors++;
         $display("FAIL async_reset: valid,busy,done,err,stage=%b required 0",
                  {bfly_valid_o, busy_o, done_o, err_o, stage_o});
      end
      wb_due.delete();
      hold_pend = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      wb_done_i = 1'b0;
      bfly_ready_i = 1'b0;
   endtask

   // Test sequence and summary.
   initial begin
      test_reset();
      test_full_run();
      test_max_outstanding();
      test_stage_barrier();
      test_random_ready();
      test_abort_restart();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
